// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver for the Bluetooth serial link. Receives frames of
// DATA_BITS payload bits (LSB first), an optional parity bit and one or two stop
// bits. Each bit is decided by a 3-sample majority vote around mid-bit. A start
// bit that votes high is rejected as a glitch. Completed frames, including those
// with framing or parity errors, land in a one-entry holding register with a
// read handshake and sticky overrun detection.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate in bit/s
//   DATA_BITS  payload bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active high
//   get        asynchronous serial input, idles high
//   rd         consume pulse: clears valid and overrun when valid is set
//   data       payload of the most recent frame, held until the next frame
//   valid      data holds a frame that has not been read yet
//   frame_err  a stop bit of the frame in data was sampled low
//   parity_err parity mismatch on the frame in data (0 when PARITY = 0)
//   overrun    sticky: a frame was written over an unread one
//   busy       receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 get,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    // Bit period rounded to the nearest clock, and the mid-bit point.
    localparam int BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CNT_W   = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    // Three sample points straddling mid-bit; the vote is taken on the last one.
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);

    localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);

    // Elaboration-time guard against parameter sets the timing cannot support.
    if (BIT_CYC < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_cfg: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 2-of-3 majority of the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns 1 when the received parity bit does not match the payload.
    // Odd parity wants XOR(data, p) = 1, even parity wants XOR(data, p) = 0.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (PARITY)
            32'sd1:  return ~x;
            32'sd2:  return x;
            default: return 1'b0;
        endcase
    endfunction

    logic [2:0]           sync_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           idx_r;
    logic                 smp_a_r;
    logic                 smp_b_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 stop_err_r;
    logic                 busy_r;

    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;

    logic                 start_edge_s;
    logic                 decide_s;
    logic                 bit_s;
    logic                 frame_done_s;

    // sync_r[2] is the oldest, fully synchronised copy of the line.
    assign start_edge_s = sync_r[2] & ~sync_r[1];
    assign decide_s     = (state_r != ST_IDLE) && (cnt_r == SMP_C);
    assign bit_s        = majority3(smp_a_r, smp_b_r, sync_r[2]);
    // Decision cycle of the last stop bit: the frame is handed over here,
    // half a bit early, so a following start edge is never missed.
    assign frame_done_s = decide_s && (state_r == ST_STOP) && (idx_r == IDX_STOP_LAST);

    // Three-flop synchroniser; resets to idle-high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[1:0], get};
        end
    end

    // Receive FSM: bit timing, mid-bit sampling, majority vote and frame assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            idx_r      <= 4'd0;
            smp_a_r    <= 1'b1;
            smp_b_r    <= 1'b1;
            shift_r    <= {DATA_BITS{1'b0}};
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_r    <= ST_START;
                        cnt_r      <= CNT_ZERO;
                        idx_r      <= 4'd0;
                        stop_err_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    // The counter free-runs across bit boundaries; states advance
                    // at the vote point, so each state owns the bit being voted.
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (cnt_r == SMP_A) begin
                        smp_a_r <= sync_r[2];
                    end
                    if (cnt_r == SMP_B) begin
                        smp_b_r <= sync_r[2];
                    end
                    if (decide_s) begin
                        case (state_r)
                            ST_START: begin
                                if (bit_s) begin
                                    // Start bit voted high: glitch, drop silently.
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end else begin
                                    state_r <= ST_DATA;
                                    idx_r   <= 4'd0;
                                end
                            end
                            ST_DATA: begin
                                // LSB arrives first; after DATA_BITS shifts it sits at bit 0.
                                shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
                                if (idx_r == IDX_DATA_LAST) begin
                                    idx_r   <= 4'd0;
                                    state_r <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                end else begin
                                    idx_r <= idx_r + 4'd1;
                                end
                            end
                            ST_PARITY: begin
                                par_bit_r <= bit_s;
                                idx_r     <= 4'd0;
                                state_r   <= ST_STOP;
                            end
                            ST_STOP: begin
                                if (!bit_s) begin
                                    stop_err_r <= 1'b1;
                                end
                                if (idx_r == IDX_STOP_LAST) begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end else begin
                                    idx_r <= idx_r + 4'd1;
                                end
                            end
                            default: begin
                                // Unreachable encodings recover to idle.
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Holding register and read handshake; a new frame takes priority over rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= {DATA_BITS{1'b0}};
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (frame_done_s) begin
            data_r       <= shift_r;
            frame_err_r  <= stop_err_r | ~bit_s;
            parity_err_r <= parity_bad(shift_r, par_bit_r);
            valid_r      <= 1'b1;
            // Overwriting an unread frame is an overrun; a same-cycle rd
            // consumes the old frame, so overrun is left as it was.
            if (valid_r && !rd) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (rd && valid_r) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_r;
            overrun_r <= overrun_r;
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at
// BIT_CYC = 10, driven by a frame generator that builds the bit sequence from
// the payload and line format, with expected outputs derived from the same
// frame description.
module tb_uart_rx_cfg;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = 10;
    localparam int HALF    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] get;
    logic [2:0] rd;
    logic [7:0] data [3];
    logic [2:0] valid, frame_err, parity_err, overrun, busy;

    int errors = 0;
    int checks = 0;

    int par_cfg  [3] = '{0, 2, 0};
    int stop_cfg [3] = '{1, 1, 2};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .get(get[0]), .rd(rd[0]), .data(data[0]), .valid(valid[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]), .busy(busy[0]));

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .get(get[1]), .rd(rd[1]), .data(data[1]), .valid(valid[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]), .busy(busy[1]));

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .get(get[2]), .rd(rd[2]), .data(data[2]), .valid(valid[2]),
        .frame_err(frame_err[2]), .parity_err(parity_err[2]), .overrun(overrun[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd(input int u);
        rd[u] = 1'b1;
        tick(1);
        rd[u] = 1'b0;
    endtask

    // Drives one frame on unit u. glitch_bit selects a frame bit (0 = start)
    // whose centre cycle is inverted; -1 for none. The line is left high.
    task automatic send_frame(input int u, input logic [7:0] d, input logic flip_par,
                              input logic [1:0] stop_val, input int glitch_bit);
        logic bits_q [$];
        logic p;
        bits_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits_q.push_back(d[i]);
        if (par_cfg[u] != 0) begin
            p = (par_cfg[u] == 1) ? ~(^d) : (^d);
            bits_q.push_back(p ^ flip_par);
        end
        for (int s = 0; s < stop_cfg[u]; s++) bits_q.push_back(stop_val[s]);
        foreach (bits_q[i]) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                get[u] = (i == glitch_bit && c == HALF) ? ~bits_q[i] : bits_q[i];
                tick(1);
            end
        end
        get[u] = 1'b1;
    endtask

    function automatic logic exp_ferr(input int u, input logic [1:0] stop_val);
        return (stop_val[0] == 1'b0) || (stop_cfg[u] == 2 && stop_val[1] == 1'b0);
    endfunction

    // Hard time limit so the run always ends.
    initial begin
        #600_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int lat;
        logic exp_valid [3];
        logic exp_ovr   [3];

        rst = 1'b1;
        get = 3'b111;
        rd  = 3'b000;
        tick(3);
        check("rst_data",   32'(data[0]), 32'h0);
        check("rst_valid",  32'(valid),   32'h0);
        check("rst_ferr",   32'(frame_err), 32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_ovr",    32'(overrun), 32'h0);
        check("rst_busy",   32'(busy),    32'h0);
        rst = 1'b0;
        tick(5);

        // 8N1 0xA5, measure latency. Line falls before edge 1; the start edge is
        // seen two edges later, then E+1+(N-1)*BIT_CYC+HALF+2 with N = 10.
        lat = 2 + 1 + 9 * BIT_CYC + HALF + 2;
        first = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
            begin
                for (int k = 1; k <= 100; k++) begin
                    @(posedge clk);
                    #2;
                    if (valid[0] && first == 0) first = k;
                end
            end
        join
        check("a5_latency", 32'(first), 32'(lat));
        check("a5_data", 32'(data[0]), 32'hA5);
        check("a5_ferr", 32'(frame_err[0]), 32'h0);
        check("a5_perr", 32'(parity_err[0]), 32'h0);
        check("a5_busy", 32'(busy[0]), 32'h0);
        pulse_rd(0);
        check("a5_rd_valid", 32'(valid[0]), 32'h0);
        check("a5_rd_hold", 32'(data[0]), 32'hA5);

        // 8E1 with wrong parity, then a good frame clears parity_err.
        send_frame(1, 8'h37, 1'b1, 2'b11, -1);
        check("e1_bad_data", 32'(data[1]), 32'h37);
        check("e1_bad_perr", 32'(parity_err[1]), 32'h1);
        check("e1_bad_valid", 32'(valid[1]), 32'h1);
        pulse_rd(1);
        send_frame(1, 8'hC4, 1'b0, 2'b11, -1);
        check("e1_good_data", 32'(data[1]), 32'hC4);
        check("e1_good_perr", 32'(parity_err[1]), 32'h0);
        pulse_rd(1);

        // Three-cycle low glitch on idle line: false start.
        get[0] = 1'b0;
        tick(3);
        get[0] = 1'b1;
        tick(2);
        check("glitch_busy_hi", 32'(busy[0]), 32'h1);
        tick(7);
        check("glitch_busy_lo", 32'(busy[0]), 32'h0);
        check("glitch_valid", 32'(valid[0]), 32'h0);

        // One-cycle glitch in the centre of data bit 3 is voted out.
        send_frame(0, 8'h3C, 1'b0, 2'b11, 4);
        check("vote_data", 32'(data[0]), 32'h3C);
        pulse_rd(0);

        // Two frames without a read: overrun.
        send_frame(0, 8'h11, 1'b0, 2'b11, -1);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1);
        check("ovr_data", 32'(data[0]), 32'h22);
        check("ovr_flag", 32'(overrun[0]), 32'h1);
        check("ovr_valid", 32'(valid[0]), 32'h1);
        pulse_rd(0);
        check("ovr_rd_valid", 32'(valid[0]), 32'h0);
        check("ovr_rd_flag", 32'(overrun[0]), 32'h0);

        // Stop bit low: framing error, payload still delivered.
        send_frame(0, 8'h7E, 1'b0, 2'b10, -1);
        check("ferr_data", 32'(data[0]), 32'h7E);
        check("ferr_flag", 32'(frame_err[0]), 32'h1);
        tick(BIT_CYC);
        pulse_rd(0);
        send_frame(2, 8'h96, 1'b0, 2'b01, -1);
        check("n2_ferr_data", 32'(data[2]), 32'h96);
        check("n2_ferr_flag", 32'(frame_err[2]), 32'h1);
        tick(BIT_CYC);
        pulse_rd(2);
        send_frame(2, 8'h69, 1'b0, 2'b11, -1);
        check("n2_good_data", 32'(data[2]), 32'h69);
        check("n2_good_ferr", 32'(frame_err[2]), 32'h0);
        pulse_rd(2);

        // Break: one zero frame with framing error, then nothing while low.
        get[0] = 1'b0;
        tick(300);
        check("brk_valid", 32'(valid[0]), 32'h1);
        check("brk_data", 32'(data[0]), 32'h0);
        check("brk_ferr", 32'(frame_err[0]), 32'h1);
        check("brk_busy", 32'(busy[0]), 32'h0);
        pulse_rd(0);
        tick(50);
        check("brk_no_new", 32'(valid[0]), 32'h0);
        get[0] = 1'b1;
        tick(20);

        // Reset part-way through data bit 4 of a frame.
        send_frame(0, 8'h81, 1'b0, 2'b11, -1);
        get[0] = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            get[0] = 1'(8'h99 >> i);
            tick(BIT_CYC);
        end
        get[0] = 1'b1;
        tick(HALF);
        check("prerst_busy", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        tick(1);
        check("midrst_data", 32'(data[0]), 32'h0);
        check("midrst_valid", 32'(valid[0]), 32'h0);
        check("midrst_busy", 32'(busy[0]), 32'h0);
        rst = 1'b0;
        tick(30);
        check("midrst_no_out", 32'(valid[0]), 32'h0);
        send_frame(0, 8'h5A, 1'b0, 2'b11, -1);
        check("postrst_data", 32'(data[0]), 32'h5A);
        check("postrst_ferr", 32'(frame_err[0]), 32'h0);
        pulse_rd(0);

        // Randomised frames against the handshake model.
        for (int u = 0; u < 3; u++) begin
            exp_valid[u] = 1'b0;
            exp_ovr[u]   = 1'b0;
        end
        for (int it = 0; it < 15; it++) begin
            int         u;
            int         gl;
            logic [7:0] d;
            logic       flip;
            logic [1:0] sv;
            u    = int'($urandom_range(0, 2));
            d    = 8'($urandom);
            flip = (u == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            sv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            gl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd(u);
                exp_valid[u] = 1'b0;
                exp_ovr[u]   = 1'b0;
            end
            send_frame(u, d, flip, sv, gl);
            exp_ovr[u]   = exp_ovr[u] | exp_valid[u];
            exp_valid[u] = 1'b1;
            check("rnd_data",  32'(data[u]), 32'(d));
            check("rnd_ferr",  32'(frame_err[u]), 32'(exp_ferr(u, sv)));
            check("rnd_perr",  32'(parity_err[u]), 32'(flip));
            check("rnd_valid", 32'(valid[u]), 32'(exp_valid[u]));
            check("rnd_ovr",   32'(overrun[u]), 32'(exp_ovr[u]));
            if (exp_ferr(u, sv)) begin
                tick(BIT_CYC + int'($urandom_range(0, 4)));
            end else begin
                tick(int'($urandom_range(0, 4)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
